// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared KNN field widths, record geometry and fetch state encoding
package knn_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int LABEL_W_DEF = 8;

  // Each training record is two bus words: {x,y} then label.
  localparam int REC_STRIDE = 8;
  localparam int WORD_OFS   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_GAP0,
    ST_RD1,
    ST_PUSH,
    ST_FIN
  } fetch_state_e;

endpackage

// File: rtl/iob_native_rd_master.sv
// rtl/iob_native_rd_master.sv - single-outstanding native read initiator with mandatory idle gap
module iob_native_rd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic                rsp_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i
);

  logic gap_q;
  logic gap_d;

  // The requester holds req_i/addr_i until rsp_o, so the bus fields stay stable.
  assign m_valid_o  = req_i & ~gap_q;
  assign m_addr_o   = m_valid_o ? addr_i : '0;
  assign m_wdata_o  = '0;
  assign m_wstrb_o  = '0;
  assign rsp_o      = m_valid_o & m_ready_i;
  assign rsp_data_o = m_rdata_i;
  assign gap_d      = rsp_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/knn_point_fetch.sv
// rtl/knn_point_fetch.sv - fetches a block of KNN training points over the native bus and streams them out
module knn_point_fetch
  import knn_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int COORD_W = COORD_W_DEF,
  parameter int LABEL_W = LABEL_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_points,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic [COORD_W-1:0]  pt_x,
  output logic [COORD_W-1:0]  pt_y,
  output logic [LABEL_W-1:0]  pt_label,
  output logic [CNT_W-1:0]    pt_index,
  output logic                busy,
  output logic                done
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [LABEL_W-1:0]  lbl_q, lbl_d;
  logic                abort_q, abort_d;

  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_rsp;
  logic [DATA_W-1:0]   rd_data;
  logic                abort_any;
  logic [CNT_W-1:0]    idx_inc;

  iob_native_rd_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (rd_req),
    .addr_i     (rd_addr),
    .rsp_o      (rd_rsp),
    .rsp_data_o (rd_data),
    .m_valid_o  (m_valid),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_wstrb_o  (m_wstrb),
    .m_rdata_i  (m_rdata),
    .m_ready_i  (m_ready)
  );

  // An abort seen mid-read is remembered until the bus transaction retires.
  assign abort_any = abort | abort_q;
  assign idx_inc   = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    lbl_d   = lbl_q;
    abort_d = abort_q;
    rd_req  = 1'b0;
    rd_addr = cur_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (num_points == '0) begin
            state_d = ST_FIN;
          end else begin
            cur_d   = base_addr;
            cnt_d   = num_points;
            idx_d   = '0;
            state_d = ST_RD0;
          end
        end
      end
      ST_RD0: begin
        rd_req = 1'b1;
        if (abort) abort_d = 1'b1;
        if (rd_rsp) begin
          x_d     = rd_data[2*COORD_W-1:COORD_W];
          y_d     = rd_data[COORD_W-1:0];
          state_d = abort_any ? ST_FIN : ST_GAP0;
        end
      end
      ST_GAP0: begin
        state_d = abort_any ? ST_FIN : ST_RD1;
      end
      ST_RD1: begin
        rd_req  = 1'b1;
        rd_addr = cur_q + ADDR_W'(WORD_OFS);
        if (abort) abort_d = 1'b1;
        if (rd_rsp) begin
          lbl_d   = rd_data[LABEL_W-1:0];
          state_d = abort_any ? ST_FIN : ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (pt_ready) begin
          idx_d   = idx_inc;
          cur_d   = cur_q + ADDR_W'(REC_STRIDE);
          state_d = (abort || idx_inc == cnt_q) ? ST_FIN : ST_RD0;
        end else if (abort) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lbl_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lbl_q   <= lbl_d;
      abort_q <= abort_d;
    end
  end

  assign pt_valid = (state_q == ST_PUSH);
  assign pt_x     = x_q;
  assign pt_y     = y_q;
  assign pt_label = lbl_q;
  assign pt_index = idx_q;
  assign done     = (state_q == ST_FIN);
  // Busy covers the accepting cycle too, so an empty fetch still shows one busy cycle.
  assign busy     = (state_q == ST_RD0) || (state_q == ST_GAP0) || (state_q == ST_RD1) ||
                    (state_q == ST_PUSH) || ((state_q == ST_IDLE) && start);

endmodule

// File: tb/tb_knn_point_fetch.sv
// tb/tb_knn_point_fetch.sv - randomized self-checking bench for knn_point_fetch
module tb_knn_point_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [15:0] num_points;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        pt_valid;
  logic        pt_ready;
  logic [15:0] pt_x;
  logic [15:0] pt_y;
  logic [7:0]  pt_label;
  logic [15:0] pt_index;
  logic        busy;
  logic        done;

  knn_point_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .num_points (num_points),
    .m_valid    (m_valid),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .pt_x       (pt_x),
    .pt_y       (pt_y),
    .pt_label   (pt_label),
    .pt_index   (pt_index),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_pt_cyc = -1;
  int done_cnt = 0;
  int mv_cnt = 0;
  int viol = 0;

  int mem_mode = 0;
  int mem_lat = 0;
  bit mem_rand = 0;
  int sink_stall = 0;
  bit sink_rand = 0;
  int cur_stall = 0;
  int scnt = 0;

  logic [31:0] rd_log[$];
  logic [55:0] pt_log[$];

  int          wcnt = 0;
  int          lat = 0;
  bit          pend = 0;
  bit          done_prev = 0;
  logic [31:0] pend_addr = '0;
  bit          prev_wait = 0;
  logic [55:0] prev_fields = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return a[2] ? 32'h0000_0002 : 32'h0005_0007;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ (a >> 7);
  endfunction

  // Memory responder: zero or more wait cycles per transaction, checks bus protocol.
  initial begin : mem_agent
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ready = 1'b0; pend = 0; done_prev = 0; wcnt = 0;
      end else begin
        if (m_wdata !== 32'h0 || m_wstrb !== 4'h0) viol++;
        if (m_valid) begin
          mv_cnt++;
          if (done_prev) viol++;
          if (pend && m_addr !== pend_addr) viol++;
          if (!pend) begin
            wcnt = 0;
            lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
          end
          pend_addr = m_addr;
          if (wcnt >= lat) begin
            m_ready = 1'b1; m_rdata = mem_word(m_addr);
            rd_log.push_back(m_addr);
            pend = 0; done_prev = 1;
          end else begin
            m_ready = 1'b0; m_rdata = $urandom;
            wcnt++; pend = 1; done_prev = 0;
          end
        end else begin
          m_ready = 1'b0; pend = 0; done_prev = 0;
        end
      end
    end
  end

  // Point sink: per-point stall, logs accepted points, checks hold-while-stalled.
  initial begin : sink_agent
    pt_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pt_ready = 1'b0; scnt = 0; prev_wait = 0;
      end else if (pt_valid) begin
        if (first_pt_cyc < 0) first_pt_cyc = cyc;
        if (prev_wait && {pt_x, pt_y, pt_label, pt_index} !== prev_fields) viol++;
        if (scnt < cur_stall) begin
          pt_ready = 1'b0; scnt++;
        end else begin
          pt_ready = 1'b1;
        end
        if (pt_ready) begin
          pt_log.push_back({pt_x, pt_y, pt_label, pt_index});
          scnt = 0;
          cur_stall = sink_rand ? int'($urandom_range(0, 3)) : sink_stall;
          prev_wait = 0;
        end else begin
          prev_wait = 1;
          prev_fields = {pt_x, pt_y, pt_label, pt_index};
        end
      end else begin
        pt_ready = 1'b0; prev_wait = 0;
      end
    end
  end

  always @(negedge clk) if (rst_n && done) done_cnt <= done_cnt + 1;

  task automatic clear_logs();
    rd_log.delete();
    pt_log.delete();
    done_cnt = 0;
    mv_cnt = 0;
    viol = 0;
    first_pt_cyc = -1;
    scnt = 0;
    cur_stall = sink_rand ? int'($urandom_range(0, 3)) : sink_stall;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge clk);
    base_addr = b; num_points = n; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; num_points = 16'($urandom);
  endtask

  task automatic wait_done(input bit noise, input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      start = 1'b0;
      @(negedge clk);
      if (done) begin ok = 1; break; end
      if (noise && $urandom_range(0, 5) == 0) begin
        start = 1'b1; base_addr = $urandom; num_points = 16'($urandom);
      end
    end
    start = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s done_timeout got none want done", tag); end
  endtask

  task automatic run_fetch(input logic [31:0] b, input int n, input bit noise, input string tag);
    logic [31:0] a, w0, w1;
    logic [55:0] exp_pt;
    bit ok;
    clear_logs();
    do_start(b, 16'(n));
    wait_done(noise, tag, ok);
    if (!ok) return;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_log.size() != 2 * n) begin
      errors++; $display("FAIL %s rd_count got %0d want %0d", tag, rd_log.size(), 2 * n);
    end else begin
      for (int i = 0; i < 2 * n; i++) begin
        a = b + 32'(8 * (i / 2)) + ((i % 2) ? 32'd4 : 32'd0);
        checks++;
        if (rd_log[i] !== a) begin
          errors++; $display("FAIL %s rd_addr[%0d] got %h want %h", tag, i, rd_log[i], a); break;
        end
      end
    end
    checks++;
    if (pt_log.size() != n) begin
      errors++; $display("FAIL %s pt_count got %0d want %0d", tag, pt_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        a = b + 32'(8 * i);
        w0 = mem_word(a);
        w1 = mem_word(a + 32'd4);
        exp_pt = {w0[31:16], w0[15:0], w1[7:0], 16'(i)};
        checks++;
        if (pt_log[i] !== exp_pt) begin
          errors++; $display("FAIL %s point[%0d] got %h want %h", tag, i, pt_log[i], exp_pt); break;
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL %s protocol_violations got %0d want 0", tag, viol); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; base_addr = '0; num_points = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, pt_valid, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {m_valid, pt_valid, busy, done});
    end
    checks++;
    if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", m_addr); end
    checks++;
    if ({pt_x, pt_y, pt_label, pt_index} !== 56'h0) begin
      errors++; $display("FAIL reset_point got %h want 0", {pt_x, pt_y, pt_label, pt_index});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    mem_mode = 0; mem_lat = 0; mem_rand = 0; sink_stall = 0; sink_rand = 0;
    run_fetch(32'h0000_1000, 3, 0, "basic");
    checks++;
    if (first_pt_cyc - start_cyc < 4) begin
      errors++; $display("FAIL basic_latency got %0d want >=4", first_pt_cyc - start_cyc);
    end
  endtask

  task automatic test_zero_count();
    clear_logs();
    @(negedge clk);
    base_addr = 32'h0000_4000; num_points = 16'd0; start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start got %b want 1", busy); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done got done,busy=%b want 10", {done, busy}); end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_after got done,busy=%b want 00", {done, busy}); end
    repeat (4) @(negedge clk);
    checks++;
    if (mv_cnt != 0) begin errors++; $display("FAIL zero_no_read got %0d m_valid cycles want 0", mv_cnt); end
  endtask

  task automatic test_backpressure();
    mem_mode = 1; mem_lat = 3; mem_rand = 0; sink_stall = 5; sink_rand = 0;
    run_fetch(32'h2000_0040, 3, 0, "backpressure");
    mem_lat = 0; sink_stall = 0;
  endtask

  task automatic test_abort_rd1();
    bit ok;
    logic [31:0] b;
    b = 32'h0000_8000;
    mem_mode = 1; mem_lat = 2; mem_rand = 0; sink_stall = 0; sink_rand = 0;
    clear_logs();
    do_start(b, 16'd3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_valid && m_addr == b + 32'd4) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_rd1_reach got none want RD1 request"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(0, "abort_rd1", ok);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== b || rd_log[1] !== b + 32'd4) begin
      errors++; $display("FAIL abort_rd1_reads got %0d reads want 2 (base, base+4)", rd_log.size());
    end
    checks++;
    if (pt_log.size() != 0) begin errors++; $display("FAIL abort_rd1_points got %0d want 0", pt_log.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL abort_rd1_done got %0d want 1", done_cnt); end
    mem_lat = 0;
    run_fetch(32'h0000_9000, 2, 0, "after_abort");
  endtask

  task automatic test_abort_push();
    bit ok;
    mem_mode = 1; mem_lat = 0; mem_rand = 0; sink_rand = 0;
    sink_stall = 1000;
    clear_logs();
    do_start(32'h0000_A000, 16'd3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pt_valid) begin ok = 1; break; end
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!ok || pt_valid !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL abort_push_drop got pt_valid=%b done=%b want 0 1", pt_valid, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pt_log.size() != 0 || rd_log.size() != 2) begin
      errors++; $display("FAIL abort_push_counts got pts=%0d reads=%0d want 0 2", pt_log.size(), rd_log.size());
    end
    sink_stall = 0;
    clear_logs();
    do_start(32'h0000_B000, 16'd3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pt_valid) begin ok = 1; break; end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || pt_log.size() != 1 || rd_log.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL abort_with_ready got pts=%0d reads=%0d done=%0d want 1 2 1",
                         pt_log.size(), rd_log.size(), done_cnt);
    end else begin
      checks++;
      if (pt_log[0][15:0] !== 16'd0) begin errors++; $display("FAIL abort_with_ready_idx got %0d want 0", pt_log[0][15:0]); end
    end
  endtask

  task automatic test_wrap();
    mem_mode = 1; mem_lat = 0; mem_rand = 0; sink_stall = 0; sink_rand = 0;
    run_fetch(32'hFFFF_FFF8, 2, 0, "wrap");
  endtask

  task automatic test_reset_mid_push();
    bit ok;
    mem_mode = 1; mem_lat = 0; mem_rand = 0; sink_rand = 0; sink_stall = 1000;
    clear_logs();
    do_start(32'h0000_C000, 16'd3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pt_valid) begin ok = 1; break; end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {m_valid, pt_valid, busy, done} !== 4'b0 || m_addr !== 32'h0) begin
      errors++; $display("FAIL midreset_ctrl got %b addr=%h want 0000 0", {m_valid, pt_valid, busy, done}, m_addr);
    end
    checks++;
    if ({pt_x, pt_y, pt_label, pt_index} !== 56'h0) begin
      errors++; $display("FAIL midreset_point got %h want 0", {pt_x, pt_y, pt_label, pt_index});
    end
    @(negedge clk);
    rst_n = 1'b1;
    sink_stall = 0;
    run_fetch(32'h0000_0300, 3, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] b;
    int n;
    mem_mode = 1; mem_rand = 1; sink_rand = 1;
    for (int k = 0; k < 8; k++) begin
      b = $urandom & 32'hFFFF_FFFC;
      n = int'($urandom_range(1, 6));
      run_fetch(b, n, 1, "random");
    end
    mem_rand = 0; sink_rand = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_abort_rd1();
    test_abort_push();
    test_wrap();
    test_random();
    test_reset_mid_push();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_point_fetch.md
Name: knn_point_fetch

Overview:
- Native-bus initiator that reads a block of training points from memory and streams them to the KNN datapath.
- It is the master-side counterpart of the KNN slave peripheral.
- Software programs a base address and a point count, then pulses start.
- The block issues read transactions on the native interface (valid/addr/wdata/wstrb -> rdata/ready) and presents each decoded point on a valid/ready stream.

Parameters:
- ADDR_W, 32, byte address width of the native master port.
- DATA_W, 32, native bus data width (fixed at 32; coordinates are packed two per word).
- COORD_W, 16, width of each coordinate; 2*COORD_W must equal DATA_W.
- LABEL_W, 8, width of the class label.
- CNT_W, 16, width of the point count and the point index.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  single-cycle pulse; begins a fetch when idle.
- abort  in  1  single-cycle pulse; stops the fetch at the next safe point.
- base_addr  in  ADDR_W  byte address of the first record; sampled on an accepted start.
- num_points  in  CNT_W  number of records to fetch; sampled on an accepted start.
- m_valid  out  1  native request valid.
- m_addr  out  ADDR_W  native request byte address.
- m_wdata  out  DATA_W  tied to 0.
- m_wstrb  out  DATA_W/8  tied to 0 (reads only).
- m_rdata  in  DATA_W  read data; valid while m_ready=1.
- m_ready  in  1  native response strobe.
- pt_valid  out  1  point stream valid.
- pt_ready  in  1  point stream ready.
- pt_x  out  COORD_W  x coordinate.
- pt_y  out  COORD_W  y coordinate.
- pt_label  out  LABEL_W  class label.
- pt_index  out  CNT_W  zero-based index of the presented point.
- busy  out  1  high from an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse on completion or abort.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. m_valid, pt_valid, busy and done are 0. m_addr, pt_x, pt_y, pt_label and pt_index are 0.
- Record layout: two consecutive 32-bit words.
  - word0 = {x[31:16], y[15:0]}.
  - word1 = label in bits [LABEL_W-1:0]; upper bits are ignored.
  - Record i sits at base_addr + 8*i. The address wraps modulo 2^ADDR_W.
- Native rules:
  - m_valid, m_addr and m_wstrb are held stable until the cycle m_ready=1. That cycle completes the transaction.
  - m_valid drops for at least one cycle between transactions.
  - There is at most one outstanding request.
- States:
  - IDLE: a start is accepted here only. If num_points==0, go to FIN. Otherwise latch base/count, clear the index and go to RD0.
  - RD0: m_valid=1, m_addr=cur. On m_ready, capture x/y from m_rdata and go to GAP0.
  - GAP0: m_valid=0, then go to RD1.
  - RD1: m_valid=1, m_addr=cur+4. On m_ready, capture the label and go to PUSH.
  - PUSH: pt_valid=1 with registered fields stable. On pt_ready, advance the index and cur+=8. If index+1==count go to FIN, else go to RD0.
  - FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Latency: the first pt_valid comes no earlier than 4 cycles after start, assuming zero-wait m_ready (RD0, GAP0, RD1, PUSH).
- Back-pressure: while pt_ready=0, PUSH holds all pt_* outputs stable and issues no new read.
- start while busy: ignored, with no effect on any latched value.
- abort:
  - In RD0 or RD1: the pending transaction is finished first (the request is not dropped while m_ready is low). Then go to FIN with no further pt_valid.
  - In PUSH: pt_valid drops at once, the point is discarded, then go to FIN.
  - In GAP0: go to FIN.
  - In IDLE: ignored.
- Simultaneous start+abort in IDLE: start wins; the abort is ignored.
- Simultaneous abort and pt_ready in PUSH: the handshake completes and is counted, then go to FIN.
- Counter width: the index is CNT_W bits, so num_points max is 2^CNT_W-1.

Decomposition:
- Shared package (knn_pkg):
  - state encoding constants.
  - record stride (8) and word offset (4).
  - COORD_W and LABEL_W defaults, shared with the KNN core so field widths match.
- One natural sub-module: iob_native_rd_master. It owns the single-request read handshake (hold-until-ready, mandatory gap cycle) and is reusable by other fetch engines.
- The top FSM sequences records and the stream.

Test Plan:
- base=0x1000, n=3, zero-wait memory with word0=0x00050007 and word1=0x2 per record:
  - reads at 0x1000, 0x1004, 0x1008, 0x100C, 0x1010, 0x1014.
  - three points out, each x=5, y=7, label=2, index 0..2.
  - one done pulse.
- n=0 -> no m_valid ever; done pulses 1 cycle after start; busy high exactly 1 cycle.
- Memory with 3-cycle m_ready latency and pt_ready low for 5 cycles in PUSH -> m_addr/m_valid and pt_* remain stable throughout; no extra reads.
- abort during RD1 with m_ready delayed 2 cycles -> the RD1 transaction completes; no pt_valid; done pulses; the next start fetches correctly.
- base=0xFFFFFFF8, n=2 -> second record read at 0x00000000 and 0x00000004 (wrap).
- rst_n asserted mid-PUSH -> all outputs 0 asynchronously; after release, start with a fresh config restarts from index 0.
